// File: rtl/merge_logic_if.sv
// -----------------------------------------------------------------------------
// merge_logic_if
//   Lane and output-stream signals of the two-lane merger.
//   Lane side : push_D0/push_D1 write strobes, data_in_D0/data_in_D1 words,
//               pause_D0/pause_D1 back-pressure returned to the lane sources.
//   Out side  : pop_out downstream ready, data_out merged word, valid_out.
//   Modports  : master = traffic source/sink around the merger,
//               slave  = the merger itself.
// -----------------------------------------------------------------------------
interface merge_logic_if;
  logic       push_D0;
  logic       push_D1;
  logic [5:0] data_in_D0;
  logic [5:0] data_in_D1;
  logic       pop_out;
  logic [5:0] data_out;
  logic       valid_out;
  logic       pause_D0;
  logic       pause_D1;

  modport master (
    output push_D0, push_D1, data_in_D0, data_in_D1, pop_out,
    input  data_out, valid_out, pause_D0, pause_D1
  );

  modport slave (
    input  push_D0, push_D1, data_in_D0, data_in_D1, pop_out,
    output data_out, valid_out, pause_D0, pause_D1
  );
endinterface

// File: rtl/merge_logic.sv
// -----------------------------------------------------------------------------
// merge_logic
//   Merges two 6-bit lanes (D0, D1) into one registered output stream. Each
//   lane has an 8-entry FIFO; a five-state FSM (RESET, INIT, IDLE, ACTIVE,
//   ERROR) gates pushes and pops. The almost-full threshold is loaded from
//   umbral_Ds while in INIT with init=1.
//
// Ports
//   clk        : clock, all state updates on its rising edge
//   reset      : synchronous, active-high reset
//   init       : threshold-load request
//   umbral_Ds  : 4-bit almost-full threshold
//   bus        : merge_logic_if.slave (lane pushes, pause, pop/data/valid)
//   error_out, active_out, idle_out : FSM state flags
//   empty_out  : both lane FIFOs empty
//
// Configuration
//   RR_ARB_EN  : defined   -> round-robin between lanes when both hold data
//                undefined -> fixed priority, D0 first
// -----------------------------------------------------------------------------
module merge_logic (
  input  logic          clk,
  input  logic          reset,
  input  logic          init,
  input  logic [3:0]    umbral_Ds,
  merge_logic_if.slave  bus,
  output logic          error_out,
  output logic          active_out,
  output logic          idle_out,
  output logic          empty_out
);

  typedef enum logic [2:0] {
    ST_RESET,
    ST_INIT,
    ST_IDLE,
    ST_ACTIVE,
    ST_ERROR
  } state_t;

  localparam logic [3:0] DEPTH = 4'd8;

  state_t     state, state_next;

  logic [5:0] mem [2][8];
  logic [2:0] wr_ptr [2];
  logic [2:0] rd_ptr [2];
  logic [3:0] count  [2];

  logic [3:0] threshold;
  logic [5:0] data_q;
  logic       valid_q;

  logic [1:0] push_req;
  logic [5:0] data_in [2];
  logic [1:0] full;
  logic [1:0] nonempty;
  logic [1:0] wr;
  logic [1:0] pop;
  logic [1:0] ovf;
  logic       push_state;
  logic       pop_en;
  logic       sel;

`ifdef RR_ARB_EN
  logic       last_grant;
`endif

  assign push_req   = {bus.push_D1, bus.push_D0};
  assign data_in[0] = bus.data_in_D0;
  assign data_in[1] = bus.data_in_D1;
  assign push_state = (state == ST_IDLE) || (state == ST_ACTIVE);

  // Lane status, arbitration and push/pop qualification.
  // NOTE: every signal written in always_comb gets a default first so that no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    full     = '0;
    nonempty = '0;
    wr       = '0;
    pop      = '0;
    ovf      = '0;
    sel      = 1'b0;

    for (int i = 0; i < 2; i++) begin
      full[i]     = (count[i] == DEPTH);
      nonempty[i] = (count[i] != 4'd0);
    end

    pop_en = (state == ST_ACTIVE) && bus.pop_out && (|nonempty);

`ifdef RR_ARB_EN
    // Alternate only when both lanes compete; a lone lane is always served.
    if (nonempty[0] && nonempty[1]) sel = ~last_grant;
    else                            sel = ~nonempty[0];
`else
    sel = ~nonempty[0];
`endif

    for (int i = 0; i < 2; i++) begin
      pop[i] = pop_en && (sel == i[0]);
      // A full lane can still take a word when its head leaves this cycle.
      wr[i]  = push_state && push_req[i] && (!full[i] || pop[i]);
      ovf[i] = push_state && push_req[i] &&  full[i] && !pop[i];
    end
  end

  // FSM next state.
  always_comb begin
    state_next = state;
    case (state)
      ST_RESET:  state_next = ST_INIT;
      ST_INIT:   if (!init) state_next = ST_IDLE;
      ST_IDLE: begin
        if (|ovf)      state_next = ST_ERROR;
        else if (|wr)  state_next = ST_ACTIVE;
        else if (init) state_next = ST_INIT;
      end
      ST_ACTIVE: begin
        if (|ovf)                       state_next = ST_ERROR;
        else if (!(|nonempty) && !(|wr)) state_next = ST_IDLE;
      end
      ST_ERROR:  state_next = ST_ERROR;
      default:   state_next = ST_RESET;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_RESET;
    else       state <= state_next;
  end

  // Pointers, counts, threshold and the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      threshold <= 4'd6;
      data_q    <= '0;
      valid_q   <= 1'b0;
`ifdef RR_ARB_EN
      last_grant <= 1'b1;
`endif
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wr[i])  wr_ptr[i] <= wr_ptr[i] + 3'd1;
        if (pop[i]) rd_ptr[i] <= rd_ptr[i] + 3'd1;
        count[i] <= count[i] + {3'b000, wr[i]} - {3'b000, pop[i]};
      end
      if ((state == ST_INIT) && init) threshold <= umbral_Ds;
      valid_q <= pop_en;
      if (pop_en) data_q <= mem[sel][rd_ptr[sel]];
`ifdef RR_ARB_EN
      if (pop_en) last_grant <= sel;
`endif
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the counts and pointers
  // define which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (wr[i]) mem[i][wr_ptr[i]] <= data_in[i];
    end
  end

  // A count at 8 pauses even when the threshold is 9..15.
  assign bus.pause_D0 = (count[0] >= threshold) || full[0];
  assign bus.pause_D1 = (count[1] >= threshold) || full[1];
  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;

  assign error_out  = (state == ST_ERROR);
  assign active_out = (state == ST_ACTIVE);
  assign idle_out   = (state == ST_IDLE);
  assign empty_out  = !(|nonempty);

endmodule

// File: tb/tb_merge_logic.sv
// -----------------------------------------------------------------------------
// tb_merge_logic
//   Directed bench for merge_logic: reset, threshold load, single-word
//   latency, back-pressure, lane arbitration order, overflow error and reset
//   during a transfer. Inputs change 1 time unit after a rising edge and
//   outputs are compared there, away from the edge.
// -----------------------------------------------------------------------------
module tb_merge_logic;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic [3:0] umbral_Ds;
  logic       error_out, active_out, idle_out, empty_out;

  int compared   = 0;
  int mismatched = 0;

  merge_logic_if bus ();

  merge_logic dut (
    .clk        (clk),
    .reset      (reset),
    .init       (init),
    .umbral_Ds  (umbral_Ds),
    .bus        (bus.slave),
    .error_out  (error_out),
    .active_out (active_out),
    .idle_out   (idle_out),
    .empty_out  (empty_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.push_D0    = 1'b0;
    bus.push_D1    = 1'b0;
    bus.data_in_D0 = 6'h00;
    bus.data_in_D1 = 6'h00;
    bus.pop_out    = 1'b0;
  endtask

  logic [5:0] order [4];

  initial begin
    reset = 1'b1;
    init  = 1'b0;
    umbral_Ds = 4'd0;
    idle_inputs();

    // Reset state.
    step();
    step();
    check("rst_data_out",  {2'b0, bus.data_out}, 8'h00);
    check("rst_valid_out", {7'b0, bus.valid_out}, 8'h00);
    check("rst_flags", {5'b0, error_out, active_out, idle_out}, 8'h00);
    check("rst_empty", {7'b0, empty_out}, 8'h01);
    check("rst_pause", {6'b0, bus.pause_D1, bus.pause_D0}, 8'h00);

    // Threshold load: RESET->INIT, two INIT cycles latching 4, then IDLE.
    reset = 1'b0;
    init  = 1'b1;
    umbral_Ds = 4'd4;
    step();
    step();
    check("init_not_idle", {7'b0, idle_out}, 8'h00);
    step();
    init = 1'b0;
    umbral_Ds = 4'd0;
    step();
    check("init_idle", {7'b0, idle_out}, 8'h01);
    check("init_empty", {7'b0, empty_out}, 8'h01);
    check("init_data_out", {2'b0, bus.data_out}, 8'h00);

    // Single word: push in cycle N, appears with valid at N+2.
    bus.push_D0 = 1'b1;
    bus.data_in_D0 = 6'h15;
    bus.pop_out = 1'b1;
    step();
    bus.push_D0 = 1'b0;
    check("lat_n1_valid", {7'b0, bus.valid_out}, 8'h00);
    check("lat_active", {7'b0, active_out}, 8'h01);
    step();
    check("lat_n2_valid", {7'b0, bus.valid_out}, 8'h01);
    check("lat_n2_data", {2'b0, bus.data_out}, 8'h15);
    step();
    check("lat_back_idle", {7'b0, idle_out}, 8'h01);
    check("lat_valid_drop", {7'b0, bus.valid_out}, 8'h00);
    check("lat_data_hold", {2'b0, bus.data_out}, 8'h15);

    // Back-pressure on D1 with threshold 4.
    bus.pop_out = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      bus.push_D1 = 1'b1;
      bus.data_in_D1 = 6'(k);
      step();
      check($sformatf("pause_D1_at_%0d", k), {7'b0, bus.pause_D1}, (k >= 4) ? 8'h01 : 8'h00);
      check($sformatf("pause_D0_at_%0d", k), {7'b0, bus.pause_D0}, 8'h00);
    end
    bus.push_D1 = 1'b0;
    bus.pop_out = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("drain_D1_%0d", k), {2'b0, bus.data_out}, 8'(k));
      check($sformatf("drain_valid_%0d", k), {7'b0, bus.valid_out}, 8'h01);
    end
    check("drain_pause_off", {7'b0, bus.pause_D1}, 8'h00);
    step();
    check("drain_idle", {7'b0, idle_out}, 8'h01);

    // Arbitration order with both lanes loaded.
    bus.pop_out = 1'b0;
    bus.push_D0 = 1'b1;
    bus.push_D1 = 1'b1;
    bus.data_in_D0 = 6'h01;
    bus.data_in_D1 = 6'h21;
    step();
    bus.data_in_D0 = 6'h02;
    bus.data_in_D1 = 6'h22;
    step();
    idle_inputs();
`ifdef RR_ARB_EN
    order[0] = 6'h01; order[1] = 6'h21; order[2] = 6'h02; order[3] = 6'h22;
`else
    order[0] = 6'h01; order[1] = 6'h02; order[2] = 6'h21; order[3] = 6'h22;
`endif
    bus.pop_out = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("arb_word_%0d", k), {2'b0, bus.data_out}, {2'b0, order[k]});
    end
    step();
    check("arb_empty", {7'b0, empty_out}, 8'h01);

    // Overflow: fill D0, then a 9th push with no pop.
    bus.pop_out = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.push_D0 = 1'b1;
      bus.data_in_D0 = 6'h30 + 6'(k);
      step();
    end
    check("full_no_error", {7'b0, error_out}, 8'h00);
    check("full_pause_D0", {7'b0, bus.pause_D0}, 8'h01);
    bus.data_in_D0 = 6'h3f;
    step();
    idle_inputs();
    check("ovf_error", {7'b0, error_out}, 8'h01);
    check("ovf_not_active", {7'b0, active_out}, 8'h00);
    bus.pop_out = 1'b1;
    step();
    step();
    check("ovf_error_held", {7'b0, error_out}, 8'h01);
    check("ovf_no_pop", {7'b0, bus.valid_out}, 8'h00);

    // Reset during a transfer with 3 words queued.
    bus.pop_out = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    step();
    check("rerst_idle", {7'b0, idle_out}, 8'h01);
    for (int k = 0; k < 3; k++) begin
      bus.push_D0 = 1'b1;
      bus.data_in_D0 = 6'h0a + 6'(k);
      step();
    end
    bus.push_D0 = 1'b0;
    check("queued_not_empty", {7'b0, empty_out}, 8'h00);
    check("queued_pause_thr6", {7'b0, bus.pause_D0}, 8'h00);
    bus.pop_out = 1'b1;
    reset = 1'b1;
    step();
    check("midrst_empty", {7'b0, empty_out}, 8'h01);
    check("midrst_valid", {7'b0, bus.valid_out}, 8'h00);
    check("midrst_flags", {5'b0, error_out, active_out, idle_out}, 8'h00);
    check("midrst_data", {2'b0, bus.data_out}, 8'h00);
    reset = 1'b0;
    idle_inputs();
    step();
    check("midrst_valid_after", {7'b0, bus.valid_out}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
